// File: rtl/param_shift_reg.sv
// WIDTH-bit register with parallel load and a multi-cycle shift engine.
// Define PSR_PARITY_EN to add a registered Parity output (^Q).
module param_shift_reg #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Load,
  input  logic [WIDTH-1:0] Dato,
  input  logic             Start,
  input  logic [1:0]       Mode,
  input  logic [AMT_W-1:0] Amount,
  input  logic             SerIn,
  output logic [WIDTH-1:0] Q,
  output logic             SerOut,
  output logic             Busy,
`ifdef PSR_PARITY_EN
  output logic             Done,
  output logic             Parity
`else
  output logic             Done
`endif
);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic             r_ser;
  logic [AMT_W-1:0] r_cnt;
  logic [1:0]       r_mode;
  logic             r_done;

  logic [WIDTH-1:0] w_shift;
  logic             w_sout;
  logic [WIDTH-1:0] w_q_next;

  always_comb begin
    w_shift = r_q;
    w_sout  = r_ser;
    unique case (r_mode)
      2'b00: begin
        w_shift = {r_q[WIDTH-2:0], SerIn};
        w_sout  = r_q[WIDTH-1];
      end
      2'b01: begin
        w_shift = {SerIn, r_q[WIDTH-1:1]};
        w_sout  = r_q[0];
      end
      2'b10: begin
        w_shift = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_sout  = r_q[WIDTH-1];
      end
      default: begin
        w_shift = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
        w_sout  = r_q[0];
      end
    endcase
  end

  // Next Q is shared by the state register and the parity register.
  always_comb begin
    w_q_next = r_q;
    if (Enable) begin
      if (r_state == S_IDLE) begin
        if (Load) w_q_next = Dato;
      end else begin
        w_q_next = w_shift;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_ser   <= 1'b0;
      r_cnt   <= '0;
      r_mode  <= 2'b00;
      r_done  <= 1'b0;
    end else if (Enable) begin
      r_q    <= w_q_next;
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (!Load && Start) begin
            if (Amount == '0) begin
              r_done <= 1'b1;
            end else begin
              r_mode  <= Mode;
              r_cnt   <= Amount;
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_ser <= w_sout;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == AMT_W'(1)) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef PSR_PARITY_EN
  logic r_par;

  always_ff @(posedge Clk) begin
    if (Reset) r_par <= 1'b0;
    else if (Enable) r_par <= ^w_q_next;
  end

  assign Parity = r_par;
`endif

  assign Q      = r_q;
  assign SerOut = r_ser;
  assign Busy   = (r_state == S_SHIFT);
  // A pending pulse is masked during a stall and reappears once enabled.
  assign Done   = r_done & Enable;

endmodule
